arbiter_grant_mux: RTL and testbench

Downstream consumer of the weighted round-robin arbiter. It presents the per-requester valid vector to the arbiter as `request` and accepts the arbiter's one-hot `grant_valid`. It returns `grant_ready` and moves the granted requester's payload, tagged with its index, into a 2-entry registered output buffer drained over a valid/ready interface. Optionally it keeps per-requester grant statistics.

---
 rtl/arbiter_grant_mux_if.sv | 28 ++
 rtl/arbiter_grant_mux.sv | 122 ++++++++++++
 tb/tb_arbiter_grant_mux.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/arbiter_grant_mux_if.sv
// Handshake bundle between requesters, the arbiter grant and the output buffer drain.
// slave is the arbiter_grant_mux side; master drives the requester/grant/drain side.
interface arbiter_grant_mux_if #(
  parameter int unsigned P_REQUESTER_NUM = 4,
  parameter int unsigned P_DATA_W        = 32,
  parameter int unsigned P_ID_W          = $clog2(P_REQUESTER_NUM)
);
  logic [P_REQUESTER_NUM-1:0]          req_valid;
  logic [P_REQUESTER_NUM*P_DATA_W-1:0] req_data;
  logic [P_REQUESTER_NUM-1:0]          req_ready;
  logic [P_REQUESTER_NUM-1:0]          request;
  logic [P_REQUESTER_NUM-1:0]          grant_valid;
  logic                                grant_ready;
  logic                                m_valid;
  logic [P_DATA_W-1:0]                 m_data;
  logic [P_ID_W-1:0]                   m_id;
  logic                                m_ready;

  modport slave (
    input  req_valid, req_data, grant_valid, m_ready,
    output req_ready, request, grant_ready, m_valid, m_data, m_id
  );

  modport master (
    output req_valid, req_data, grant_valid, m_ready,
    input  req_ready, request, grant_ready, m_valid, m_data, m_id
  );
endinterface

// File: rtl/arbiter_grant_mux.sv
// Moves the granted requester's payload, tagged with its index, into a 2-entry output FIFO.
// Optional per-requester saturating grant counters under `ARBITER_GRANT_STATS_EN.
module arbiter_grant_mux #(
  parameter int unsigned  P_REQUESTER_NUM = 4,
  parameter int unsigned  P_DATA_W        = 32,
  parameter int unsigned  P_STAT_W        = 16,
  localparam int unsigned P_ID_W          = $clog2(P_REQUESTER_NUM)
) (
  input  logic                    clk,
  input  logic                    rst,
  arbiter_grant_mux_if.slave      bus,
  output logic                    grant_err,
  input  logic [P_ID_W-1:0]       stat_sel,
  output logic [P_STAT_W-1:0]     stat_cnt
);

  typedef struct packed {
    logic [P_ID_W-1:0]   id;
    logic [P_DATA_W-1:0] data;
  } entry_t;

  entry_t      mem_q [2];
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, wr_ptr_q;
  logic        grant_err_q;

  logic                       grant_onehot;
  logic [P_ID_W-1:0]          grant_idx;
  logic                       grant_req_valid;
  logic [P_DATA_W-1:0]        grant_data;
  logic                       push, pop;

  always_comb begin
    grant_onehot    = (|bus.grant_valid) &&
                      ((bus.grant_valid & (bus.grant_valid - P_REQUESTER_NUM'(1))) == '0);
    grant_idx       = '0;
    grant_req_valid = 1'b0;
    grant_data      = '0;
    for (int unsigned i = 0; i < P_REQUESTER_NUM; i++) begin
      if (bus.grant_valid[i]) begin
        grant_idx       = P_ID_W'(i);
        grant_req_valid = bus.req_valid[i];
        grant_data      = bus.req_data[i*P_DATA_W +: P_DATA_W];
      end
    end
  end

  // No ready-through-pop: a full buffer refuses grants even while draining.
  assign bus.grant_ready = !rst && (count_q != 2'd2);
  assign bus.req_ready   = (bus.grant_ready && grant_onehot) ? bus.grant_valid : '0;
  assign bus.request     = bus.req_valid;

  assign push = bus.grant_ready && grant_onehot && grant_req_valid;
  assign pop  = bus.m_valid && bus.m_ready;

  assign bus.m_valid = (count_q != 2'd0);
  assign bus.m_data  = mem_q[rd_ptr_q].data;
  assign bus.m_id    = mem_q[rd_ptr_q].id;
  assign grant_err   = grant_err_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      count_q     <= 2'd0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      grant_err_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= '{id: grant_idx, data: grant_data};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
      if ((|bus.grant_valid) && !grant_onehot) begin
        grant_err_q <= 1'b1;
      end
    end
  end

`ifdef ARBITER_GRANT_STATS_EN
  logic [P_STAT_W-1:0] stat_q [P_REQUESTER_NUM];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < P_REQUESTER_NUM; i++) begin
        stat_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < P_REQUESTER_NUM; i++) begin
        if (push && (grant_idx == P_ID_W'(i)) && (stat_q[i] != '1)) begin
          stat_q[i] <= stat_q[i] + P_STAT_W'(1);
        end
      end
    end
  end

  always_comb begin
    stat_cnt = '0;
    if (32'(stat_sel) < P_REQUESTER_NUM) begin
      stat_cnt = stat_q[stat_sel];
    end
  end
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_arbiter_grant_mux.sv
// Directed bench for arbiter_grant_mux with a FIFO scoreboard of expected {id, data} outputs.
module tb_arbiter_grant_mux;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 2;
  localparam int unsigned SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          grant_err;
  logic [IW-1:0] stat_sel;
  logic [SW-1:0] stat_cnt;

  arbiter_grant_mux_if #(.P_REQUESTER_NUM(N), .P_DATA_W(DW)) bus ();

  arbiter_grant_mux #(
    .P_REQUESTER_NUM(N),
    .P_DATA_W       (DW),
    .P_STAT_W       (SW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .grant_err(grant_err),
    .stat_sel (stat_sel),
    .stat_cnt (stat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [DW-1:0] base);
    for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = base + DW'(i);
  endtask

  task automatic expect_push(input int k);
    sb.push_back('{id: IW'(k), data: bus.req_data[k*DW +: DW]});
  endtask

  // Output monitor: every accepted head entry must match the oldest expected push.
  always @(negedge clk) begin
    if (!rst && bus.m_valid && bus.m_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 64'(bus.m_data), 64'hDEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("m_data", 64'(bus.m_data), 64'(e.data));
        check("m_id", 64'(bus.m_id), 64'(e.id));
      end
    end
  end

  initial begin
    rst             = 1'b1;
    bus.req_valid   = 4'b1111;
    bus.grant_valid = 4'b0100;
    bus.m_ready     = 1'b0;
    stat_sel        = '0;
    set_data(32'hD0);

    tick();
    tick();
    check("rst_grant_ready", 64'(bus.grant_ready), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_m_valid", 64'(bus.m_valid), 64'd0);
    check("rst_m_data", 64'(bus.m_data), 64'd0);
    check("rst_m_id", 64'(bus.m_id), 64'd0);
    check("rst_grant_err", 64'(grant_err), 64'd0);
    check("rst_stat", 64'(stat_cnt), 64'd0);

    // First cycle after release pushes requester 2.
    rst = 1'b0;
    #1;
    check("rel_grant_ready", 64'(bus.grant_ready), 64'd1);
    check("rel_req_ready", 64'(bus.req_ready), 64'b0100);
    check("request", 64'(bus.request), 64'b1111);
    expect_push(2);
    tick();
    bus.grant_valid = 4'b0000;
    bus.m_ready     = 1'b1;
    check("first_m_valid", 64'(bus.m_valid), 64'd1);
    check("first_m_id", 64'(bus.m_id), 64'd2);
    tick();
    check("drained", 64'(bus.m_valid), 64'd0);

    // Back-to-back streaming, one transfer per cycle.
    set_data(32'hA0);
    for (int i = 0; i < N; i++) begin
      bus.grant_valid = 4'(1 << i);
      expect_push(i);
      tick();
      check("stream_valid", 64'(bus.m_valid), 64'd1);
      check("stream_id", 64'(bus.m_id), 64'(i));
      check("stream_data", 64'(bus.m_data), 64'(32'hA0 + i));
    end
    bus.grant_valid = 4'b0000;
    tick();
    check("stream_end", 64'(bus.m_valid), 64'd0);

    // Fill to two entries with the drain stalled.
    bus.m_ready     = 1'b0;
    set_data(32'h100);
    bus.grant_valid = 4'b0001;
    expect_push(0);
    tick();
    bus.grant_valid = 4'b0010;
    expect_push(1);
    tick();
    bus.grant_valid = 4'b0100;
    #1;
    check("full_grant_ready", 64'(bus.grant_ready), 64'd0);
    check("full_req_ready", 64'(bus.req_ready), 64'd0);
    check("full_hold_id", 64'(bus.m_id), 64'd0);
    bus.m_ready = 1'b1;
    #1;
    check("full_pop_grant_ready", 64'(bus.grant_ready), 64'd0);
    tick();
    bus.m_ready = 1'b0;
    #1;
    check("after_pop_grant_ready", 64'(bus.grant_ready), 64'd1);
    check("after_pop_req_ready", 64'(bus.req_ready), 64'b0100);
    expect_push(2);
    tick();
    bus.grant_valid = 4'b0000;
    bus.m_ready     = 1'b1;
    tick();
    tick();
    tick();
    check("fill_drained", 64'(bus.m_valid), 64'd0);

    // Non-one-hot grant is sticky until reset.
    bus.grant_valid = 4'b0011;
    #1;
    check("err_req_ready", 64'(bus.req_ready), 64'd0);
    tick();
    check("err_set", 64'(grant_err), 64'd1);
    check("err_no_push", 64'(bus.m_valid), 64'd0);
    bus.grant_valid = 4'b1000;
    expect_push(3);
    tick();
    bus.grant_valid = 4'b0000;
    tick();
    check("err_sticky", 64'(grant_err), 64'd1);

    // Reset mid-operation discards a buffered entry.
    bus.m_ready     = 1'b0;
    bus.grant_valid = 4'b0001;
    tick();
    bus.grant_valid = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.m_ready = 1'b1;
    check("rst2_m_valid", 64'(bus.m_valid), 64'd0);
    check("rst2_err_clear", 64'(grant_err), 64'd0);

    // Grant to a requester without valid data: no push, no error.
    bus.req_valid   = 4'b1101;
    bus.grant_valid = 4'b0010;
    #1;
    check("nv_req_ready", 64'(bus.req_ready), 64'b0010);
    tick();
    check("nv_no_push", 64'(bus.m_valid), 64'd0);
    check("nv_no_err", 64'(grant_err), 64'd0);

    // Statistics saturation.
    bus.req_valid   = 4'b1111;
    bus.grant_valid = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      expect_push(0);
      tick();
      if (i == 2) begin
`ifdef ARBITER_GRANT_STATS_EN
        check("stat_partial", 64'(stat_cnt), 64'd3);
`else
        check("stat_partial", 64'(stat_cnt), 64'd0);
`endif
      end
    end
    bus.grant_valid = 4'b0000;
    tick();
    tick();
`ifdef ARBITER_GRANT_STATS_EN
    check("stat_sat", 64'(stat_cnt), 64'd15);
`else
    check("stat_sat", 64'(stat_cnt), 64'd0);
`endif
    stat_sel = 2'd1;
    #1;
    check("stat_sel1", 64'(stat_cnt), 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
